prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time writer for the instruction/data RAM that the core fetches from (word-addressed, 32-bit).
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes those words to consecutive RAM word addresses from 0, holding the core in reset until a checksum-verified image is resident.

Parameters:
ADDR_WIDTH, 30, RAM word-address width (matches byte PC [31:2]); must be >= 16

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
ram_addr  output  ADDR_WIDTH  RAM word address
ram_din  output  32  RAM write data
ram_we  output  1  RAM write strobe, one cycle per word
cpu_hold  output  1  core held in reset / pc disabled while 1
done  output  1  image loaded and checksum OK (sticky)
error  output  1  checksum mismatch (sticky)

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: state=SYNC, in_ready=1, ram_we=0, ram_addr=0, ram_din=0, cpu_hold=1, done=0, error=0. Word count, byte lane, word index and checksum are all cleared.
- Byte transfer: a byte is accepted on a rising edge when in_valid && in_ready. in_data is ignored otherwise.
- Frame format:
  - 0xA5 sync byte.
  - N[7:0], then N[15:8]: word count, 16-bit.
  - 4*N data bytes, little-endian per word (first byte -> bits [7:0]).
  - One checksum byte = XOR of all 4*N data bytes.
- All outputs are registered.
- States:
  - SYNC: in_ready=1. Accepted 0xA5 -> LEN0. Any other byte is discarded; stay in SYNC.
  - LEN0: in_ready=1. Accept byte -> N[7:0], go to LEN1.
  - LEN1: in_ready=1. Accept byte -> N[15:8].
    - N==0: go to CSUM (expected checksum 0).
    - Otherwise: go to DATA with lane=0, index=0, csum=0.
  - DATA: in_ready=1.
    - Each accepted byte goes into lane position [8*lane+7:8*lane], and csum ^= byte.
    - Lane 0..2: lane++.
    - Lane 3: go to WRITE.
  - WRITE: exactly one cycle, in_ready=0, ram_we=1, ram_addr=index, ram_din=assembled word.
    - Next state: CSUM if index+1==N, else DATA with lane=0.
    - Index increments at the end of the cycle.
  - CSUM: in_ready=1. Accept byte.
    - Byte==csum: go to DONE.
    - Otherwise: go to ERROR.
  - DONE: in_ready=0, done=1, cpu_hold=0. Sticky until reset.
  - ERROR: in_ready=0, error=1, cpu_hold=1. Sticky until reset.
- Latency: when the 4th byte of a word is accepted at edge k, ram_we is high in the cycle after edge k. It deasserts at edge k+1. Throughput is at most 4 bytes per 5 cycles.
- ram_we is 0 in every state except WRITE. ram_addr and ram_din hold their last values when ram_we=0.
- Address range: index ranges 0..N-1 <= 65534. No wrap occurs, because ADDR_WIDTH >= 16.
- in_valid held high while in_ready=0: no byte is consumed. The same byte is accepted once in_ready returns.
- Reset mid-frame: returns to SYNC immediately, cpu_hold=1. Words already written stay in RAM; there is no rollback.
- in_valid asserted in the same cycle as reset: the byte is not accepted.
- Bytes arriving in DONE or ERROR are never accepted (in_ready=0).

Test Plan:
- Reset then frame A5 01 00 | 13 05 00 00 | 16 (0x13^0x05=0x16):
  - Required: one ram_we pulse, ram_addr=0, ram_din=0x00000513.
  - Then done=1 and cpu_hold=0 in the cycle after the checksum byte is accepted.
- Junk before sync: bytes 00 FF 5A, then a valid 2-word frame.
  - Required: junk bytes discarded.
  - Writes at addr 0 and 1 with correct words, done=1.
- Bad checksum: the single-word frame above with a final byte of 17.
  - Required: word still written to addr 0.
  - Then error=1, done=0, cpu_hold=1, in_ready=0 from then on.
- Zero-length frame A5 00 00 00:
  - Required: no ram_we, done=1.
  - Frame A5 00 00 01 instead gives error=1.
- Backpressure/throughput: in_valid held high continuously for a 3-word frame.
  - Required: in_ready drops for exactly one cycle after each 4th data byte.
  - Each write lands one cycle after its 4th byte is accepted.
  - No byte is lost or duplicated; addresses are 0, 1, 2.
- Reset mid-frame after 5 data bytes:
  - Required: next cycle state=SYNC, cpu_hold=1, done=error=0.
  - A fresh full frame then reloads correctly from addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot loader that writes a framed, checksummed byte stream into word RAM from address 0,
// holding the core in reset until a verified image is resident.
module prog_loader #(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR} state_t;
  state_t                r_state, w_state;
  logic [15:0]           r_n, w_n, r_idx, w_idx;
  logic [1:0]            r_lane, w_lane;
  logic [7:0]            r_csum, w_csum;
  logic [23:0]           r_word, w_word;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]           r_din, w_din;
  logic                  r_we, w_we, r_ready, r_done, r_err, r_hold;
  logic                  w_acc;
  assign w_acc = in_valid && r_ready;
  always_comb begin
    w_state = r_state;
    w_n     = r_n;
    w_idx   = r_idx;
    w_lane  = r_lane;
    w_csum  = r_csum;
    w_word  = r_word;
    w_addr  = r_addr;
    w_din   = r_din;
    w_we    = 1'b0;
    case (r_state)
      SYNC: if (w_acc && in_data == 8'hA5) w_state = LEN0;
      LEN0: if (w_acc) begin
        w_n[7:0] = in_data;
        w_state  = LEN1;
      end
      LEN1: if (w_acc) begin
        w_n[15:8] = in_data;
        w_lane    = 2'd0;
        w_idx     = 16'd0;
        w_csum    = 8'd0;
        w_state   = ({in_data, r_n[7:0]} == 16'd0) ? CSUM : DATA;
      end
      DATA: if (w_acc) begin
        // bytes shift in from the top, so after three lanes r_word holds {b2,b1,b0}
        w_csum = r_csum ^ in_data;
        w_word = {in_data, r_word[23:8]};
        w_lane = r_lane + 2'd1;
        if (r_lane == 2'd3) begin
          w_state = WRITE;
          w_we    = 1'b1;
          w_addr  = ADDR_WIDTH'(r_idx);
          w_din   = {in_data, r_word};
        end
      end
      WRITE: begin
        w_idx   = r_idx + 16'd1;
        w_state = (w_idx == r_n) ? CSUM : DATA;
      end
      CSUM: if (w_acc) w_state = (in_data == r_csum) ? DONE : ERROR;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SYNC;
      r_n     <= '0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_csum  <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_idx   <= w_idx;
      r_lane  <= w_lane;
      r_csum  <= w_csum;
      r_word  <= w_word;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_we    <= w_we;
      r_ready <= !(w_state inside {WRITE, DONE, ERROR});
      r_done  <= w_state == DONE;
      r_err   <= w_state == ERROR;
      r_hold  <= w_state != DONE;
    end
  end
  assign in_ready = r_ready;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign ram_we   = r_we;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign error    = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table vectors, hand-written corner sequences and random frames checked against a frame-parsing model.
module tb_prog_loader;
  localparam int AW = 30;
  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, ram_we, cpu_hold, done, error;
  logic [7:0]    in_data;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  int            n_err = 0, n_chk = 0, cyc = 0;
  logic [7:0]    s[$];
  logic [31:0]   exp_w[$];
  bit            exp_ok, gaps;
  int            wa[$], wc[$], ac[$];
  logic [31:0]   wd[$];
  typedef struct packed {
    logic [127:0] b;
    int           len;
    logic [95:0]  w;
    int           nw;
    bit           ok;
  } vec_t;
  vec_t tv[5];

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_we) begin
    wa.push_back(int'(ram_addr));
    wd.push_back(ram_din);
    wc.push_back(cyc);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reset is applied with a sync byte on the bus, which must not be taken
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst cpu_hold", cpu_hold, 1);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    wa.delete(); wd.delete(); wc.delete(); ac.delete();
  endtask

  task automatic send_byte(logic [7:0] b);
    bit rdy = 1'b0;
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      rdy = in_ready;
      t++;
      if (rdy) ac.push_back(cyc);
      @(posedge clk);
    end while (!rdy && t < 8);
    chk("byte accepted", rdy, 1);
  endtask

  // reference: skip to the first sync byte, read N, gather little-endian words, compare the XOR
  task automatic model();
    int i = 0;
    int n;
    logic [7:0] cs = 8'd0;
    exp_w.delete();
    while (i < s.size() && s[i] != 8'hA5) i++;
    i++;
    n = int'({s[i+1], s[i]});
    i += 2;
    for (int w = 0; w < n; w++) begin
      exp_w.push_back({s[i+3], s[i+2], s[i+1], s[i]});
      cs ^= s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
      i += 4;
    end
    exp_ok = (s[i] == cs);
  endtask

  task automatic run_frame(string tag);
    foreach (s[i]) send_byte(s[i]);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hA5;
    chk($sformatf("%s done", tag), done, exp_ok);
    chk($sformatf("%s error", tag), error, !exp_ok);
    chk($sformatf("%s cpu_hold", tag), cpu_hold, !exp_ok);
    chk($sformatf("%s in_ready", tag), in_ready, 0);
    repeat (3) @(negedge clk);
    chk($sformatf("%s sticky in_ready", tag), in_ready, 0);
    chk($sformatf("%s sticky done", tag), done, exp_ok);
    chk($sformatf("%s sticky error", tag), error, !exp_ok);
    in_valid = 1'b0;
    chk($sformatf("%s writes", tag), wa.size(), exp_w.size());
    foreach (exp_w[i]) if (i < wd.size()) begin
      chk($sformatf("%s addr%0d", tag, i), wa[i], i);
      chk($sformatf("%s data%0d", tag, i), wd[i], exp_w[i]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; gaps = 1'b0;
    tv[0] = '{128'h16_00_00_05_13_00_01_A5, 8, 96'h00000513, 1, 1'b1};
    tv[1] = '{128'h66_DE_AD_BE_EF_11_22_33_44_00_02_A5_5A_FF_00, 15, {32'h0, 32'hDEADBEEF, 32'h11223344}, 2, 1'b1};
    tv[2] = '{128'h17_00_00_05_13_00_01_A5, 8, 96'h00000513, 1, 1'b0};
    tv[3] = '{128'h00_00_00_A5, 4, 96'h0, 0, 1'b1};
    tv[4] = '{128'h01_00_00_A5, 4, 96'h0, 0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      do_reset();
      s.delete();
      exp_w.delete();
      for (int i = 0; i < tv[k].len; i++) s.push_back(tv[k].b[8*i +: 8]);
      for (int j = 0; j < tv[k].nw; j++) exp_w.push_back(tv[k].w[32*j +: 32]);
      exp_ok = tv[k].ok;
      run_frame($sformatf("vec%0d", k));
    end
    // continuous valid over a 3-word frame: one stall per word, write one cycle after the 4th byte
    do_reset();
    s = '{8'hA5, 8'h03, 8'h00};
    for (int i = 1; i <= 12; i++) s.push_back(8'(i));
    s.push_back(8'h0C);
    model();
    run_frame("bp");
    chk("bp accepted", ac.size(), 16);
    for (int k = 0; k + 1 < ac.size(); k++)
      chk($sformatf("bp gap%0d", k), ac[k+1] - ac[k], (k == 6 || k == 10 || k == 14) ? 2 : 1);
    for (int w = 0; w < 3; w++) if (w < wc.size() && 6 + 4*w < ac.size())
      chk($sformatf("bp wr_cycle%0d", w), wc[w], ac[6 + 4*w] + 1);
    // reset after 5 data bytes, then unsynced junk and a fresh frame
    do_reset();
    s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (s[i]) send_byte(s[i]);
    chk("mid writes", wa.size(), 1);
    if (wd.size() > 0) chk("mid data0", wd[0], 32'h44332211);
    do_reset();
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h16,
          8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    model();
    run_frame("reload");
    gaps = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [7:0] cs = 8'd0;
      int n = $urandom_range(0, 6);
      do_reset();
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j = 8'($urandom);
        s.push_back(j == 8'hA5 ? 8'h5A : j);
      end
      s.push_back(8'hA5);
      s.push_back(8'(n));
      s.push_back(8'h00);
      repeat (4 * n) begin
        logic [7:0] d = 8'($urandom);
        s.push_back(d);
        cs ^= d;
      end
      s.push_back($urandom_range(0, 3) == 0 ? cs ^ (8'd1 << $urandom_range(0, 7)) : cs);
      model();
      run_frame($sformatf("rnd%0d", r));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
